// File: rtl/system_buttons_in.sv
// system_buttons_in: Avalon-MM input PIO with synchronizer, debounce, edge capture and maskable irq
module system_buttons_in #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int EDGE_TYPE       = 1,
   parameter int RESET_LEVEL     = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   input  logic [WIDTH-1:0]  in_port,
   output logic [31:0]       readdata,
   output logic              irq
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [WIDTH-1:0] RST_VAL = (RESET_LEVEL != 0) ? '1 : '0;

   logic [WIDTH-1:0]         sync1, sync2, deb, deb_nx;
   logic [WIDTH-1:0]         irqmask, edgecapture, set_bits, clr_bits;
   logic [WIDTH-1:0][CW-1:0] cnt, cnt_nx;
   logic                     wr_en;
   logic                     unused_wd;

   assign unused_wd = ^writedata;
   assign wr_en     = chipselect & ~write_n;
   assign clr_bits  = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
   assign set_bits  = (EDGE_TYPE == 0) ? (deb_nx & ~deb) :
                      (EDGE_TYPE == 1) ? (deb & ~deb_nx) : (deb ^ deb_nx);
   assign irq       = |(edgecapture & irqmask);

   // Per-bit debounce: a mismatch must persist for a full window before deb follows sync2
   always_comb begin
      deb_nx = deb;
      cnt_nx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         deb_nx[i] = (sync2[i] != deb[i] && cnt[i] == LAST) ? sync2[i] : deb[i];
         cnt_nx[i] = (sync2[i] == deb[i] || cnt[i] == LAST) ? '0 : cnt[i] + 1'b1;
      end
   end

   // Two-flop synchronizer feeding the debounce state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= RST_VAL;
         sync2 <= RST_VAL;
         deb   <= RST_VAL;
         cnt   <= '0;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
         deb   <= deb_nx;
         cnt   <= cnt_nx;
      end
   end

   // Mask register and sticky edge capture; a same-edge set beats a W1C clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqmask     <= '0;
         edgecapture <= '0;
      end else begin
         irqmask     <= (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask;
         edgecapture <= (edgecapture & ~clr_bits) | set_bits;
      end
   end

   // Zero-latency read mux, independent of chipselect
   always_comb begin
      readdata = (address == 2'd0) ? 32'(deb) :
                 (address == 2'd1) ? 32'(sync2) :
                 (address == 2'd2) ? 32'(irqmask) : 32'(edgecapture);
   end
endmodule

// File: tb/tb_system_buttons_in.sv
// tb_system_buttons_in: scoreboard bench with directed plan steps and a random phase against a reference model
module tb_system_buttons_in;
   localparam int DEB = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] readdata;
   logic        irq;

   int vectors = 0;
   int miscompares = 0;

   logic [32:0] exp_q [$];
   string       tag_q [$];
   logic [3:0]  inq [$];
   logic [3:0]  m_deb, m_mask, m_ec;
   logic [32:0] mon_e;
   string       mon_t;

   always #5 clk = ~clk;

   system_buttons_in #(.WIDTH(4), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(1), .RESET_LEVEL(1)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata), .irq(irq)
   );

   task automatic model_reset();
      inq.delete();
      repeat (8) inq.push_back(4'hF);
      m_deb  = 4'hF;
      m_mask = 4'h0;
      m_ec   = 4'h0;
   endtask

   // deb flips once the last DEB synchronized samples all disagree with it
   task automatic model_step();
      logic [3:0] nd, clr;
      int run;
      inq.push_front(in_port);
      void'(inq.pop_back());
      nd = m_deb;
      for (int b = 0; b < 4; b++) begin
         run = 0;
         for (int k = 2; k < 2 + DEB; k++) if (inq[k][b] != m_deb[b]) run++;
         if (run == DEB) nd[b] = ~m_deb[b];
      end
      clr = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[3:0];
      m_ec  = (m_ec & ~clr) | (m_deb & ~nd);
      m_deb = nd;
   endtask

   function automatic logic [32:0] model_read(input logic [1:0] a);
      logic [3:0] v;
      v = (a == 2'd0) ? m_deb : (a == 2'd1) ? inq[1] : (a == 2'd2) ? m_mask : m_ec;
      return {28'h0, v, |(m_ec & m_mask)};
   endfunction

   task automatic cyc(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd,
                      input logic [3:0] inp, input logic use_const, input logic [32:0] cexp, input string tag);
      @(posedge clk);
      if (reset_n) model_step();
      #1;
      address = a; chipselect = cs; write_n = wn; writedata = wd; in_port = inp;
      if (cs && wn) begin
         exp_q.push_back(use_const ? cexp : model_read(a));
         tag_q.push_back(tag);
      end
   endtask

   task automatic rd(input logic [1:0] a, input logic [3:0] inp, input logic [31:0] d, input logic q, input string tag);
      cyc(a, 1'b1, 1'b1, 32'h0, inp, 1'b1, {d, q}, tag);
   endtask

   task automatic rdm(input logic [1:0] a, input logic [3:0] inp);
      cyc(a, 1'b1, 1'b1, 32'h0, inp, 1'b0, 33'h0, "random_read");
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] inp);
      cyc(a, 1'b1, 1'b0, d, inp, 1'b0, 33'h0, "");
   endtask

   task automatic idle(input logic [3:0] inp);
      cyc(2'd0, 1'b0, 1'b1, 32'h0, inp, 1'b0, 33'h0, "");
   endtask

   task automatic do_reset(input logic [3:0] inp);
      @(negedge clk);
      #1;
      chipselect = 1'b0; write_n = 1'b1; in_port = inp;
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   // Monitor: every read strobe presents readdata/irq, compared against the oldest expectation
   always @(negedge clk) begin
      if (reset_n === 1'b1 && chipselect && write_n) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_read: readdata=%h irq=%b, no expectation queued", readdata, irq);
         end else begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            if ({readdata, irq} !== mon_e) begin
               miscompares++;
               $display("FAIL %s: addr=%0d got readdata=%h irq=%b, required readdata=%h irq=%b",
                        mon_t, address, readdata, irq, mon_e[32:1], mon_e[0]);
            end
         end
      end
   end

   initial begin
      logic [3:0] cur;
      int r;
      address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0; in_port = 4'hF;
      reset_n = 1'b0;
      do_reset(4'hF);
      rd(2'd0, 4'hF, 32'hF, 1'b0, "rst_data");
      rd(2'd2, 4'hF, 32'h0, 1'b0, "rst_mask");
      rd(2'd3, 4'hF, 32'h0, 1'b0, "rst_ec");
      // clean press on bit 0
      rd(2'd1, 4'hE, 32'hF, 1'b0, "raw_t0");
      rd(2'd1, 4'hE, 32'hF, 1'b0, "raw_t1");
      rd(2'd1, 4'hE, 32'hE, 1'b0, "raw_t2");
      rd(2'd0, 4'hE, 32'hF, 1'b0, "deb_t3");
      rd(2'd3, 4'hE, 32'h0, 1'b0, "ec_t4");
      rd(2'd0, 4'hE, 32'hF, 1'b0, "deb_t5");
      rd(2'd3, 4'hE, 32'h1, 1'b0, "ec_t6");
      rd(2'd0, 4'hE, 32'hE, 1'b0, "deb_t7");
      // 3-cycle glitch on bit 1
      rd(2'd0, 4'hC, 32'hE, 1'b0, "glitch_g0");
      rd(2'd0, 4'hC, 32'hE, 1'b0, "glitch_g1");
      rd(2'd1, 4'hC, 32'hC, 1'b0, "glitch_raw");
      repeat (6) rd(2'd0, 4'hE, 32'hE, 1'b0, "glitch_data");
      rd(2'd3, 4'hE, 32'h1, 1'b0, "glitch_ec");
      // irq path
      wr(2'd2, 32'hABCD_0001, 4'hE);
      rd(2'd2, 4'hE, 32'h1, 1'b1, "mask_irq");
      wr(2'd3, 32'hF0F0_0001, 4'hE);
      rd(2'd3, 4'hE, 32'h0, 1'b0, "ec_clear");
      // bit 2 press with W1C on the same edge deb[2] falls
      rd(2'd0, 4'hA, 32'hE, 1'b0, "col_c0");
      rd(2'd0, 4'hA, 32'hE, 1'b0, "col_c1");
      rd(2'd1, 4'hA, 32'hA, 1'b0, "col_raw");
      rd(2'd0, 4'hA, 32'hE, 1'b0, "col_c3");
      rd(2'd0, 4'hA, 32'hE, 1'b0, "col_c4");
      wr(2'd3, 32'h4, 4'hA);
      rd(2'd3, 4'hA, 32'h4, 1'b0, "collide_set_wins");
      wr(2'd2, 32'h4, 4'hA);
      rd(2'd0, 4'hA, 32'hA, 1'b1, "collide_irq_mask");
      wr(2'd3, 32'h4, 4'hA);
      rd(2'd3, 4'hA, 32'h0, 1'b0, "collide_clear");
      // release bit 0: rising edge must not capture
      repeat (6) rd(2'd3, 4'hB, 32'h0, 1'b0, "rise_ec");
      rd(2'd0, 4'hB, 32'hB, 1'b0, "rise_data");
      rd(2'd3, 4'hB, 32'h0, 1'b0, "rise_ignored");
      // reset two cycles into a falling window
      rd(2'd1, 4'hA, 32'hB, 1'b0, "rm_raw0");
      rd(2'd1, 4'hA, 32'hB, 1'b0, "rm_raw1");
      rd(2'd1, 4'hA, 32'hA, 1'b0, "rm_raw2");
      rd(2'd0, 4'hA, 32'hB, 1'b0, "rm_data3");
      idle(4'hA);
      do_reset(4'hA);
      repeat (5) rd(2'd0, 4'hA, 32'hF, 1'b0, "rst_window");
      rd(2'd0, 4'hA, 32'hA, 1'b0, "rst_redone");
      rd(2'd3, 4'hA, 32'h5, 1'b0, "rst_ec");
      // random phase against the reference model
      cur = 4'hA;
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) cur[b] = ~cur[b];
         r = $urandom_range(99);
         if (r < 70) rdm(2'($urandom_range(3)), cur);
         else if (r < 80) wr(2'd2, $urandom, cur);
         else if (r < 94) wr(2'd3, $urandom, cur);
         else if (r == 99 && $urandom_range(4) == 0) do_reset(cur);
         else idle(cur);
      end
      repeat (3) idle(cur);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
